// File: rtl/pong_field_renderer_pkg.sv
// rtl/pong_field_renderer_pkg.sv - shared types and defaults for the pong field renderer
package pong_pkg;

  localparam int COORD_W   = 10;
  localparam int COLOR_W   = 1;
  localparam int BORDER_PX = 4;

  typedef struct packed {
    logic [COORD_W-1:0]   x;
    logic [COORD_W-1:0]   y;
    logic [COORD_W-1:0]   w;
    logic [COORD_W-1:0]   h;
    logic [3*COLOR_W-1:0] color;
    logic                 en;
  } rect_t;

endpackage

// File: rtl/pong_field_renderer_rect_hit.sv
// rtl/pong_field_renderer_rect_hit.sv - registered hit test of one rectangle slot
module rect_hit
  import pong_pkg::*;
#(
  parameter int CW = pong_pkg::COORD_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  input  logic [CW-1:0] rx,
  input  logic [CW-1:0] ry,
  input  logic [CW-1:0] rw,
  input  logic [CW-1:0] rh,
  input  logic          en,
  output logic          hit
);

  // Right/top edges in CW+1 bits so a slot hanging off the field never wraps to x=0.
  logic [CW:0] x_end;
  logic [CW:0] y_end;
  logic        in_x;
  logic        in_y;

  assign x_end = {1'b0, rx} + {1'b0, rw};
  assign y_end = {1'b0, ry} + {1'b0, rh};
  assign in_x  = (x >= rx) && ({1'b0, x} < x_end);
  assign in_y  = (y >= ry) && ({1'b0, y} < y_end);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hit <= 1'b0;
    else     hit <= en && in_x && in_y;
  end

endmodule

// File: rtl/pong_field_renderer.sv
// rtl/pong_field_renderer.sv - multi-rectangle field renderer with per-frame commit; FIELD_BORDER_EN adds an inverted-bg border
module pong_field_renderer
  import pong_pkg::*;
#(
  parameter int NUM_RECTS = 4,
  parameter int IDX_W     = 2,
  parameter int COLOR_W   = pong_pkg::COLOR_W,
  parameter int COORD_W   = pong_pkg::COORD_W,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [COORD_W-1:0]   pos_h,
  input  logic [COORD_W-1:0]   pos_v,
  input  logic                 blank,
  input  logic [3*COLOR_W-1:0] bg_color,
  input  logic                 upd_valid,
  output logic                 upd_ready,
  input  logic [IDX_W-1:0]     upd_idx,
  input  logic [COORD_W-1:0]   upd_x,
  input  logic [COORD_W-1:0]   upd_y,
  input  logic [COORD_W-1:0]   upd_w,
  input  logic [COORD_W-1:0]   upd_h,
  input  logic [3*COLOR_W-1:0] upd_color,
  input  logic                 upd_en,
  output logic                 frame_start,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue
);

  localparam logic [COORD_W-1:0] V_TOP = COORD_W'(V_RES - 1);

  logic [COORD_W-1:0]   sh_x [NUM_RECTS];
  logic [COORD_W-1:0]   sh_y [NUM_RECTS];
  logic [COORD_W-1:0]   sh_w [NUM_RECTS];
  logic [COORD_W-1:0]   sh_h [NUM_RECTS];
  logic [3*COLOR_W-1:0] sh_c [NUM_RECTS];
  logic                 sh_en[NUM_RECTS];
  logic [COORD_W-1:0]   ac_x [NUM_RECTS];
  logic [COORD_W-1:0]   ac_y [NUM_RECTS];
  logic [COORD_W-1:0]   ac_w [NUM_RECTS];
  logic [COORD_W-1:0]   ac_h [NUM_RECTS];
  logic [3*COLOR_W-1:0] ac_c [NUM_RECTS];
  logic                 ac_en[NUM_RECTS];

  logic rdy_q;
  logic commit;
  logic accept;

  assign commit    = (pos_v == COORD_W'(V_RES)) && (pos_h == '0);
  // Updates are held off on the commit edge so a write always lands in exactly one frame.
  assign upd_ready = rdy_q && !commit;
  assign accept    = upd_valid && upd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q       <= 1'b0;
      frame_start <= 1'b0;
      for (int i = 0; i < NUM_RECTS; i++) begin
        sh_x[i] <= '0; sh_y[i] <= '0; sh_w[i] <= '0; sh_h[i] <= '0; sh_c[i] <= '0; sh_en[i] <= 1'b0;
        ac_x[i] <= '0; ac_y[i] <= '0; ac_w[i] <= '0; ac_h[i] <= '0; ac_c[i] <= '0; ac_en[i] <= 1'b0;
      end
    end else begin
      rdy_q       <= 1'b1;
      frame_start <= commit;
      for (int i = 0; i < NUM_RECTS; i++) begin
        if (accept && upd_idx == IDX_W'(i)) begin
          sh_x[i] <= upd_x; sh_y[i] <= upd_y; sh_w[i] <= upd_w;
          sh_h[i] <= upd_h; sh_c[i] <= upd_color; sh_en[i] <= upd_en;
        end
        if (commit) begin
          ac_x[i] <= sh_x[i]; ac_y[i] <= sh_y[i]; ac_w[i] <= sh_w[i];
          ac_h[i] <= sh_h[i]; ac_c[i] <= sh_c[i]; ac_en[i] <= sh_en[i];
        end
      end
    end
  end

  logic [COORD_W-1:0]   x_s1, y_s1;
  logic                 blank_s1, blank_s2;
  logic [3*COLOR_W-1:0] bg_s1, bg_s2;
  logic [NUM_RECTS-1:0] hit;
  logic                 border_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_s1 <= '0; y_s1 <= '0; blank_s1 <= 1'b1; bg_s1 <= '0;
      blank_s2 <= 1'b1; bg_s2 <= '0; border_s2 <= 1'b0;
    end else begin
      x_s1     <= pos_h;
      y_s1     <= V_TOP - pos_v;
      blank_s1 <= blank;
      bg_s1    <= bg_color;
      blank_s2 <= blank_s1;
      bg_s2    <= bg_s1;
`ifdef FIELD_BORDER_EN
      border_s2 <= (x_s1 < COORD_W'(BORDER_PX)) || (x_s1 >= COORD_W'(H_RES - BORDER_PX)) ||
                   (y_s1 < COORD_W'(BORDER_PX)) || (y_s1 >= COORD_W'(V_RES - BORDER_PX));
`else
      border_s2 <= 1'b0;
`endif
    end
  end

  for (genvar g = 0; g < NUM_RECTS; g++) begin : g_slot
    rect_hit #(.CW(COORD_W)) u_hit (
      .clk(clk), .rst(rst), .x(x_s1), .y(y_s1),
      .rx(ac_x[g]), .ry(ac_y[g]), .rw(ac_w[g]), .rh(ac_h[g]),
      .en(ac_en[g]), .hit(hit[g])
    );
  end

  logic [3*COLOR_W-1:0] color_sel;

  always_comb begin
    color_sel = bg_s2;
    for (int i = NUM_RECTS - 1; i >= 0; i--) begin
      if (hit[i]) color_sel = ac_c[i];
    end
    if (border_s2) color_sel = ~bg_s2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      red <= '0; green <= '0; blue <= '0;
    end else if (blank_s2) begin
      red <= '0; green <= '0; blue <= '0;
    end else begin
      red   <= color_sel[3*COLOR_W-1 -: COLOR_W];
      green <= color_sel[2*COLOR_W-1 -: COLOR_W];
      blue  <= color_sel[COLOR_W-1:0];
    end
  end

endmodule
